// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/sub_step.sv
// One restoring-division trial subtraction: r - b computed as r + (~b + 1) in WIDTH+1 bits.
module sub_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0] full;

  // r never exceeds 2*b-1 here, so the sign bit of the difference is the borrow
  assign full   = r + ~{1'b0, b} + {{WIDTH{1'b0}}, 1'b1};
  assign diff   = full[WIDTH-1:0];
  assign borrow = full[WIDTH];

endmodule

// File: rtl/seq_divider4.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, MSB first.
// state | meaning
// IDLE  | waiting for start
// RUN   | iterating, busy high, start ignored
// DONE  | one-cycle done pulse, results valid and held
module seq_divider4
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] part_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] part_d;
  logic [WIDTH-1:0] work_d;

  // work_q starts as the dividend and fills with quotient bits from the right
  assign shifted = {part_q, work_q[WIDTH-1]};

  sub_step #(.WIDTH(WIDTH)) u_sub_step (
    .r      (shifted),
    .b      (b_q),
    .diff   (diff),
    .borrow (borrow)
  );

  always_comb begin
    part_d = diff;
    if (borrow) part_d = shifted[WIDTH-1:0];
    work_d = {work_q[WIDTH-2:0], ~borrow};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      b_q         <= '0;
      work_q      <= '0;
      part_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (start) begin
            b_q    <= b;
            work_q <= a;
            part_q <= '0;
            cnt_q  <= CNT_LOAD;
            if (b == '0) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= a;
              dbz_q       <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              dbz_q   <= 1'b0;
            end
          end
        end
        RUN: begin
          part_q <= part_d;
          work_q <= work_d;
          if (cnt_q == '0) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= work_d;
            remainder_q <= part_d;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider4.sv
// Self-checking bench for seq_divider4: arithmetic reference model checked every cycle,
// directed scenarios with literal expectations, exhaustive sweep and random traffic.
module tb_seq_divider4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  seq_divider4 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;

  // reference model: expected outputs after each edge
  logic         m_busy = 0, m_done = 0, m_dz = 0;
  logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  bit           m_active = 0;
  int           fin = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_busy = 0; m_done = 0; m_dz = 0; m_q = '0; m_r = '0; m_active = 0;
    end else if (m_active) begin
      if (cyc == fin) begin
        m_active = 0; m_busy = 0; m_done = 1; m_q = p_q; m_r = p_r;
      end else begin
        m_busy = 1; m_done = 0;
      end
    end else if (start) begin
      if (b == '0) begin
        m_busy = 0; m_done = 1; m_dz = 1; m_q = '1; m_r = a;
      end else begin
        m_active = 1; fin = cyc + W; m_busy = 1; m_done = 0; m_dz = 0;
        p_q = a / b; p_r = a % b;
      end
    end else begin
      m_busy = 0; m_done = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("quotient", quotient, m_q);
    chk("remainder", remainder, m_r);
    chk("div_by_zero", div_by_zero, m_dz);
    if (done === 1'b1) done_cnt++;
  endtask

  // lat: cycle (start edge opens cycle 1) in which done is seen; nb: busy cycles
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int lat, output int nb);
    a = av; b = bv; start = 1;
    step();
    start = 0;
    lat = 0;
    nb = (busy === 1'b1) ? 1 : 0;
    if (done === 1'b1) lat = 1;
    for (int n = 2; n <= 20 && lat == 0; n++) begin
      step();
      if (busy === 1'b1) nb++;
      if (done === 1'b1) lat = n;
    end
    chk("op_completed", (lat != 0), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, nb, base;
    bit seen;

    rst = 1;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    rst = 0;
    step();

    run_op(4'd13, 4'd4, lat, nb);
    chk("d13_4_latency", lat, 5);
    chk("d13_4_busy_cycles", nb, 4);
    chk("d13_4_q", quotient, 3);
    chk("d13_4_r", remainder, 1);
    chk("d13_4_dz", div_by_zero, 0);
    step();
    chk("d13_4_done_one_cycle", done, 0);
    chk("d13_4_hold_q", quotient, 3);

    run_op(4'd9, 4'd0, lat, nb);
    chk("d9_0_latency", lat, 1);
    chk("d9_0_busy_cycles", nb, 0);
    chk("d9_0_q", quotient, 15);
    chk("d9_0_r", remainder, 9);
    chk("d9_0_dz", div_by_zero, 1);
    step(); step();

    // back-to-back: start held through the done cycle
    base = done_cnt;
    a = 4'd3; b = 4'd7; start = 1;
    step();
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (done === 1'b1) begin
        seen = 1;
        chk("b2b_q0", quotient, 0);
        chk("b2b_r0", remainder, 3);
      end
    end
    chk("b2b_first_done", seen, 1);
    a = 4'd15; b = 4'd1;
    step();
    chk("b2b_busy_rise", busy, 1);
    chk("b2b_done_not_extended", done, 0);
    start = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (done === 1'b1) begin
        seen = 1;
        chk("b2b_q1", quotient, 15);
        chk("b2b_r1", remainder, 0);
      end
    end
    chk("b2b_second_done", seen, 1);
    step(); step(); step();
    chk("b2b_pulses", done_cnt - base, 2);

    // reset on the 2nd RUN cycle aborts the division
    base = done_cnt;
    a = 4'd13; b = 4'd4; start = 1;
    step();
    start = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    chk("abort_busy", busy, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_dz", div_by_zero, 0);
    for (int i = 0; i < 8; i++) step();
    chk("abort_no_done", done_cnt - base, 0);

    // start during RUN is ignored
    a = 4'd13; b = 4'd4; start = 1;
    step();
    a = 4'd2; b = 4'd1;
    step(); step();
    start = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (done === 1'b1) begin
        seen = 1;
        chk("ignore_q", quotient, 3);
        chk("ignore_r", remainder, 1);
      end
    end
    chk("ignore_done", seen, 1);
    step();

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(W'(i), W'(j), lat, nb);
        if (j == 0) begin
          chk("sweep_lat0", lat, 1);
          chk("sweep_q0", quotient, 15);
          chk("sweep_r0", remainder, i);
          chk("sweep_dz0", div_by_zero, 1);
        end else begin
          chk("sweep_lat", lat, 5);
          chk("sweep_q", quotient, i / j);
          chk("sweep_r", remainder, i % j);
          chk("sweep_identity", 32'(quotient) * 32'(j) + 32'(remainder), i);
        end
      end
    end

    for (int i = 0; i < 500; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      start = ($urandom_range(0, 2) == 0);
      a     = W'($urandom);
      b     = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 15));
      step();
    end
    rst = 0; start = 0;
    for (int i = 0; i < 8; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
